// File: rtl/vga_gain_writer.sv
// Writes the AGC's three VGA gain codes to the analog VGA chain over a 3-wire serial bus.
// After each write it waits out the analog settling time, then pulses settled.
module vga_gain_writer #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [2:0]  HEADER        = 3'b101,
    parameter bit          SKIP_SAME     = 1'b1
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [4:0] vga1_control,
    input  logic [3:0] vga2_control,
    input  logic [3:0] vga3_control,
    input  logic       load,
    output logic       busy,
    output logic       settled,
    output logic       cs_n,
    output logic       sclk,
    output logic       sdata
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned WORD_W  = 13;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned CNT_MAX = (2 * CLK_DIV > SETTLE_CYCLES) ? 2 * CLK_DIV : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        SETTLE,
        SKIP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [FRAME_W-1:0]  shreg;
    logic [WORD_W-1:0]   cur_word;
    logic [WORD_W-1:0]   last_word;
    logic                last_valid;
    logic                pending;

    logic [FRAME_W-1:0]  frame_c;
    logic [WORD_W-1:0]   word_c;
    logic                skip_c;

    // Frame as it would be sent if captured this cycle
    assign frame_c = {HEADER, vga1_control, vga2_control, vga3_control};
    assign word_c  = frame_c[WORD_W-1:0];
    assign skip_c  = SKIP_SAME && last_valid && (word_c == last_word);

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            cur_word   <= '0;
            last_word  <= '0;
            last_valid <= 1'b0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            settled    <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
        end else begin
            settled <= 1'b0;
            // Loads arriving mid-operation coalesce into one deferred request
            if (state != IDLE && load) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load || pending) begin
                        shreg    <= frame_c;
                        cur_word <= word_c;
                        pending  <= 1'b0;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        busy     <= 1'b1;
                        if (skip_c) begin
                            state   <= SKIP;
                            settled <= 1'b1;
                        end else begin
                            state <= SETUP;
                            cs_n  <= 1'b0;
                            sdata <= frame_c[FRAME_W-1];
                        end
                    end
                end

                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sclk  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state      <= SETTLE;
                            cs_n       <= 1'b1;
                            sdata      <= 1'b0;
                            last_word  <= cur_word;
                            last_valid <= 1'b1;
                            settled    <= (SETTLE_CYCLES == 1);
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            sclk    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Falling sclk: present the next bit for the following rising edge
                        if (cnt == HIGH_LAST) begin
                            sclk <= 1'b0;
                            if (bit_idx != LAST_BIT) begin
                                sdata <= shreg[FRAME_W-2];
                                shreg <= {shreg[FRAME_W-2:0], 1'b0};
                            end
                        end
                    end
                end

                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        settled <= ((cnt + CNT_W'(1)) == SETTLE_LAST);
                    end
                end

                SKIP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b0;
                    sdata <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_gain_writer.sv
// Bench for vga_gain_writer: three parameterisations driven together, checked each cycle
// against a transaction-level model plus hand-computed frame/timing literals.
module tb_vga_gain_writer;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] vga1 = '0;
    logic [3:0] vga2 = '0;
    logic [3:0] vga3 = '0;
    logic       load = 1'b0;

    logic [2:0] busy_w, settled_w, cs_n_w, sclk_w, sdata_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int c0;

    // model state, per instance
    bit          m_act   [3];
    bit          m_skip  [3];
    bit          m_pend  [3];
    bit          m_lastv [3];
    int          m_start [3];
    logic [15:0] m_frame [3];
    logic [12:0] m_lastw [3];
    logic [4:0]  exp_o   [3];

    // monitor state, per instance
    logic [15:0] rx [3];
    int n_rise[3], first_rise[3], last_rise[3], n_cs[3], n_busy[3], n_settled[3], settled_cyc[3];
    logic [2:0] prev_sclk = '0;

    vga_gain_writer #(.CLK_DIV(4), .SETTLE_CYCLES(8), .HEADER(3'b101), .SKIP_SAME(1'b1)) dut0 (
        .clk(clk), .RESET(RESET), .vga1_control(vga1), .vga2_control(vga2), .vga3_control(vga3),
        .load(load), .busy(busy_w[0]), .settled(settled_w[0]), .cs_n(cs_n_w[0]), .sclk(sclk_w[0]),
        .sdata(sdata_w[0]));

    vga_gain_writer #(.CLK_DIV(4), .SETTLE_CYCLES(8), .HEADER(3'b101), .SKIP_SAME(1'b0)) dut1 (
        .clk(clk), .RESET(RESET), .vga1_control(vga1), .vga2_control(vga2), .vga3_control(vga3),
        .load(load), .busy(busy_w[1]), .settled(settled_w[1]), .cs_n(cs_n_w[1]), .sclk(sclk_w[1]),
        .sdata(sdata_w[1]));

    vga_gain_writer #(.CLK_DIV(1), .SETTLE_CYCLES(1), .HEADER(3'b101), .SKIP_SAME(1'b1)) dut2 (
        .clk(clk), .RESET(RESET), .vga1_control(vga1), .vga2_control(vga2), .vga3_control(vga3),
        .load(load), .busy(busy_w[2]), .settled(settled_w[2]), .cs_n(cs_n_w[2]), .sclk(sclk_w[2]),
        .sdata(sdata_w[2]));

    always #5 clk = ~clk;

    function automatic int cd_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int st_of(int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic bit ss_of(int i);
        return (i != 1);
    endfunction

    function automatic int op_len(int i);
        return m_skip[i] ? 1 : (33 * cd_of(i) + st_of(i));
    endfunction

    // {busy, settled, cs_n, sclk, sdata} at cycle t, derived from the operation's start cycle
    function automatic logic [4:0] expect_out(int i, int t);
        int off, cd, k, b, ph;
        logic sc, sd, cs;
        if (!m_act[i]) return 5'b00100;
        if (m_skip[i]) return 5'b11100;
        cd  = cd_of(i);
        off = t - m_start[i];
        sc  = 1'b0;
        sd  = 1'b0;
        cs  = 1'b1;
        if (off < cd) begin
            cs = 1'b0;
            sd = m_frame[i][15];
        end else if (off < 33 * cd) begin
            k  = off - cd;
            b  = k / (2 * cd);
            ph = k % (2 * cd);
            cs = 1'b0;
            sc = (ph < cd);
            sd = (ph < cd || b == 15) ? m_frame[i][15 - b] : m_frame[i][14 - b];
        end
        return {1'b1, (off == op_len(i) - 1), cs, sc, sd};
    endfunction

    // Transaction-level model: decides op boundaries from load/pending/last-word rules
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (RESET) begin
                m_act[i]   = 1'b0;
                m_pend[i]  = 1'b0;
                m_lastv[i] = 1'b0;
                m_lastw[i] = '0;
            end else if (m_act[i]) begin
                if (load) m_pend[i] = 1'b1;
                if (cyc == m_start[i] + op_len(i) - 1) begin
                    m_act[i] = 1'b0;
                    if (!m_skip[i]) begin
                        m_lastv[i] = 1'b1;
                        m_lastw[i] = m_frame[i][12:0];
                    end
                end
            end else if (load || m_pend[i]) begin
                m_frame[i] = {3'b101, vga1, vga2, vga3};
                m_skip[i]  = ss_of(i) && m_lastv[i] && (m_frame[i][12:0] == m_lastw[i]);
                m_act[i]   = 1'b1;
                m_start[i] = cyc + 1;
                m_pend[i]  = 1'b0;
            end
            exp_o[i] = expect_out(i, cyc + 1);
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 3; i++) begin
            rx[i] = '0; n_rise[i] = 0; first_rise[i] = -1; last_rise[i] = -1;
            n_cs[i] = 0; n_busy[i] = 0; n_settled[i] = 0; settled_cyc[i] = -1;
        end
    endtask

    // One clock: compare and monitor at the falling edge, then return just after the rising edge
    task automatic step();
        logic [4:0] got;
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                got = {busy_w[i], settled_w[i], cs_n_w[i], sclk_w[i], sdata_w[i]};
                checks++;
                if (got !== exp_o[i]) begin
                    errors++;
                    $display("FAIL cycle_cmp dut%0d cyc=%0d busy/settled/cs_n/sclk/sdata got %b required %b",
                             i, cyc, got, exp_o[i]);
                end
                if (sclk_w[i] && !prev_sclk[i]) begin
                    rx[i] = {rx[i][14:0], sdata_w[i]};
                    n_rise[i]++;
                    if (first_rise[i] < 0) first_rise[i] = cyc;
                    last_rise[i] = cyc;
                end
                if (!cs_n_w[i]) n_cs[i]++;
                if (busy_w[i]) n_busy[i]++;
                if (settled_w[i]) begin
                    n_settled[i]++;
                    settled_cyc[i] = cyc;
                end
            end
            prev_sclk = sclk_w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        c0 = cyc;
        step();
        load = 1'b0;
    endtask

    initial begin
        clear_mon();
        repeat (3) step();
        chk_en = 1'b1;
        step();
        RESET = 1'b0;
        step();
        check("reset_busy", 32'(busy_w), 32'h0);
        check("reset_cs_n", 32'(cs_n_w), 32'h7);
        check("reset_sclk_sdata_settled", 32'({sclk_w, sdata_w, settled_w}), 32'h0);

        // basic frame
        vga1 = 5'h13; vga2 = 4'hA; vga3 = 4'h5;
        clear_mon();
        pulse_load();
        repeat (149) step();
        check("basic_data", 32'(rx[0]), 32'hB3A5);
        check("basic_rises", n_rise[0], 16);
        check("basic_first_rise", first_rise[0], c0 + 5);
        check("basic_last_rise", last_rise[0], c0 + 125);
        check("basic_cs_low", n_cs[0], 132);
        check("basic_settled", settled_cyc[0], c0 + 140);
        check("basic_busy", n_busy[0], 140);
        check("noskip_data", 32'(rx[1]), 32'hB3A5);
        check("fast_data", 32'(rx[2]), 32'hB3A5);
        check("fast_rises", n_rise[2], 16);
        check("fast_first_rise", first_rise[2], c0 + 2);
        check("fast_busy", n_busy[2], 34);
        check("fast_settled", settled_cyc[2], c0 + 34);

        // same codes again: skipped unless SKIP_SAME=0
        clear_mon();
        pulse_load();
        repeat (149) step();
        check("skip_busy", n_busy[0], 1);
        check("skip_bus_quiet", n_cs[0] + n_rise[0], 0);
        check("skip_settled", settled_cyc[0], c0 + 1);
        check("noskip_rises", n_rise[1], 16);
        check("noskip_busy", n_busy[1], 140);
        check("fast_skip_busy", n_busy[2], 1);

        // coalescing loads during SHIFT
        RESET = 1'b1;
        step(); step();
        RESET = 1'b0;
        step();
        vga1 = 5'h13;
        clear_mon();
        pulse_load();
        repeat (29) step();
        vga1 = 5'h01;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (9) step();
        vga1 = 5'h02;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (260) step();
        check("coalesce_rises", n_rise[0], 32);
        check("coalesce_data", 32'(rx[0]), 32'hA2A5);
        check("coalesce_settled_count", n_settled[0], 2);
        check("coalesce_settled", settled_cyc[0], c0 + 281);
        check("coalesce_busy", n_busy[0], 280);

        // inputs change mid-frame without load
        vga1 = 5'h0F; vga2 = 4'h3; vga3 = 4'hC;
        clear_mon();
        pulse_load();
        repeat (19) step();
        vga1 = '0; vga2 = '0; vga3 = '0;
        repeat (150) step();
        check("midchange_data", 32'(rx[0]), 32'hAF3C);
        check("midchange_rises", n_rise[0], 16);
        check("midchange_frames", n_settled[0], 1);

        // reset in the middle of SHIFT
        vga1 = 5'h01; vga2 = 4'h1; vga3 = 4'h1;
        pulse_load();
        repeat (59) step();
        RESET = 1'b1;
        step();
        check("rst_mid_busy", 32'(busy_w[0]), 32'h0);
        check("rst_mid_cs_n", 32'(cs_n_w[0]), 32'h1);
        check("rst_mid_sclk", 32'(sclk_w[0]), 32'h0);
        RESET = 1'b0;
        step();
        clear_mon();
        pulse_load();
        repeat (150) step();
        check("after_rst_data", 32'(rx[0]), 32'hA111);
        check("after_rst_rises", n_rise[0], 16);
        check("after_rst_busy", n_busy[0], 140);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
